// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader FSM encoding, the canonical NOP word and the word width in bytes.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_BYTES,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h00000013;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_word_packer.sv
// Assembles four stream bytes into one little-endian word; a byte lands on the edge it is loaded.
// No backpressure of its own: the caller gates load_en with its handshake.
module loader_word_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load_en,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic [31:0] word
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    if (clr) begin
      byte_idx_d = '0;
      word_d     = '0;
    end else if (load_en) begin
      word_d[8*byte_idx_q +: 8] = byte_in;
      byte_idx_d                = byte_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

  // Index wraps to 0 after the top byte, so the next word starts cleanly.
  assign last_byte = (byte_idx_q == 2'(BYTES_PER_WORD - 1));
  assign word      = word_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte-stream program image into instruction memory while holding the core in reset;
// write pulses one cycle after the 4th byte, s_ready drops during writes. Option: INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  state_e        state_q, state_d;
  logic [AW:0]   n_q, n_d;
  logic [AW:0]   words_loaded_q, words_loaded_d;
  logic [AW:0]   words_inc;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          s_ready_q, s_ready_d;
  logic          mem_we_q, mem_we_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [8:0]    hdr_n;
  logic          accept;
  logic          pk_clr, pk_load, pk_last;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    chk_total;
  assign chk_total = sum_q + s_data;
`endif

  assign accept    = s_valid && s_ready_q;
  assign hdr_n     = (s_data == 8'd0) ? 9'(DEPTH) : {1'b0, s_data};
  assign words_inc = words_loaded_q + {{AW{1'b0}}, 1'b1};

  loader_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr),
    .load_en   (pk_load),
    .byte_in   (s_data),
    .last_byte (pk_last),
    .word      (mem_wdata)
  );

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    words_loaded_d = words_loaded_q;
    mem_addr_d     = mem_addr_q;
    pk_clr         = 1'b0;
    pk_load        = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    sum_d          = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d        = ST_HDR;
          words_loaded_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_d          = '0;
`endif
        end
      end
      ST_HDR: begin
        if (accept) begin
          pk_clr = 1'b1;
          if (hdr_n > 9'(DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            n_d     = hdr_n[AW:0];
            state_d = ST_BYTES;
          end
        end
      end
      ST_BYTES: begin
        if (accept) begin
          pk_load = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_d   = sum_q + s_data;
`endif
          if (pk_last) begin
            state_d    = ST_WRITE;
            mem_addr_d = words_loaded_q[AW-1:0];
          end
        end
      end
      ST_WRITE: begin
        words_loaded_d = words_inc;
        if (words_inc == n_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_BYTES;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          state_d = (chk_total == 8'd0) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are flops aligned with state_q.
    s_ready_d  = (state_d == ST_HDR) || (state_d == ST_BYTES) || (state_d == ST_CHK);
    mem_we_d   = (state_d == ST_WRITE);
    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      n_q            <= '0;
      words_loaded_q <= '0;
      mem_addr_q     <= '0;
      s_ready_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      words_loaded_q <= words_loaded_d;
      mem_addr_q     <= mem_addr_d;
      s_ready_q      <= s_ready_d;
      mem_we_q       <= mem_we_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

  assign s_ready      = s_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule
